// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard unit: forwarding select
// encodings and the default register address width.
package pipe_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam int REG_AW_DFLT = 5;

endpackage

// File: rtl/long_op_scoreboard.sv
// Busy tracker for the single long-latency functional unit (mul/div).
// Holds the destination of the op in flight and a down-counter that stays
// non-zero for LONG_LAT cycles after issue. match_o reports whether the ID
// instruction collides with it (RAW, WAW or structural); the caller gates it
// with busy_o and id_valid.
module long_op_scoreboard
  import pipe_pkg::*;
#(
  parameter int REG_AW   = REG_AW_DFLT,
  parameter int LONG_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_i,
  input  logic [REG_AW-1:0] issue_addr_i,
  input  logic              id_uses_rs_i,
  input  logic              id_uses_rt_i,
  input  logic              id_is_long_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic [REG_AW-1:0] id_wr_addr_i,
  output logic              busy_o,
  output logic              match_o
);

  localparam int CNT_W = $clog2(LONG_LAT + 1);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [REG_AW-1:0] busy_addr_q, busy_addr_d;
  logic              addr_hit;

  // Next state: a new issue reloads the counter, otherwise count down to zero.
  always_comb begin
    cnt_d       = cnt_q;
    busy_addr_d = busy_addr_q;
    if (issue_i) begin
      cnt_d       = CNT_W'(LONG_LAT);
      busy_addr_d = issue_addr_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // State register with synchronous reset; a reset abandons any op in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      busy_addr_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      busy_addr_q <= busy_addr_d;
    end
  end

  assign busy_o = (cnt_q != '0);

  // r0 never carries a real dependency, but a second long op always waits.
  assign addr_hit = (busy_addr_q != '0) &&
                    ((id_uses_rs_i && (id_rs_i == busy_addr_q)) ||
                     (id_uses_rt_i && (id_rt_i == busy_addr_q)) ||
                     (id_wr_addr_i == busy_addr_q));
  assign match_o  = addr_hit || id_is_long_i;

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard, forwarding and long-op scoreboard control for the 5-stage pipeline.
// Optional build macro HAZARD_PERF_EN adds saturating stall/flush counters;
// without it the perf outputs are tied to zero.
module pipe_hazard_unit
  import pipe_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = REG_AW_DFLT,
  parameter int LONG_LAT = 4,
  parameter int PERF_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              id_is_long,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_wr_addr,
  input  logic              ex_valid,
  input  logic              ex_wr_en,
  input  logic              ex_is_load,
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic [REG_AW-1:0] ex_wr_addr,
  input  logic [DATA_W-1:0] ex_rdata1,
  input  logic [DATA_W-1:0] ex_rdata2,
  input  logic              br_taken,
  input  logic              mem_valid,
  input  logic              mem_wr_en,
  input  logic              mem_is_load,
  input  logic [REG_AW-1:0] mem_wr_addr,
  input  logic [DATA_W-1:0] mem_result,
  input  logic              wb_valid,
  input  logic              wb_wr_en,
  input  logic [REG_AW-1:0] wb_wr_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              idex_bubble,
  output logic              flush_ifid,
  output logic              long_issue,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic [DATA_W-1:0] ex_opnd_a,
  output logic [DATA_W-1:0] ex_opnd_b,
  output logic [PERF_W-1:0] perf_stall_cnt,
  output logic [PERF_W-1:0] perf_flush_cnt
);

  logic mem_fwd_ok, wb_fwd_ok;
  logic mem_hit_a, mem_hit_b, wb_hit_a, wb_hit_b;
  logic load_use, sb_busy, sb_match, long_stall, stall;

  // A load result is not ready in MEM, so only ALU results forward from there.
  assign mem_fwd_ok = mem_valid && mem_wr_en && !mem_is_load;
  assign wb_fwd_ok  = wb_valid && wb_wr_en;

  assign mem_hit_a = mem_fwd_ok && (ex_rs != '0) && (mem_wr_addr == ex_rs);
  assign mem_hit_b = mem_fwd_ok && (ex_rt != '0) && (mem_wr_addr == ex_rt);
  assign wb_hit_a  = wb_fwd_ok  && (ex_rs != '0) && (wb_wr_addr  == ex_rs);
  assign wb_hit_b  = wb_fwd_ok  && (ex_rt != '0) && (wb_wr_addr  == ex_rt);

  // Operand muxes: the younger MEM result wins over WB.
  always_comb begin
    fwd_a_sel = FWD_RF;
    ex_opnd_a = ex_rdata1;
    fwd_b_sel = FWD_RF;
    ex_opnd_b = ex_rdata2;
    if (mem_hit_a) begin
      fwd_a_sel = FWD_MEM;
      ex_opnd_a = mem_result;
    end else if (wb_hit_a) begin
      fwd_a_sel = FWD_WB;
      ex_opnd_a = wb_data;
    end
    if (mem_hit_b) begin
      fwd_b_sel = FWD_MEM;
      ex_opnd_b = mem_result;
    end else if (wb_hit_b) begin
      fwd_b_sel = FWD_WB;
      ex_opnd_b = wb_data;
    end
  end

  assign load_use = id_valid && ex_valid && ex_is_load && ex_wr_en &&
                    (ex_wr_addr != '0) &&
                    ((id_uses_rs && (id_rs == ex_wr_addr)) ||
                     (id_uses_rt && (id_rt == ex_wr_addr)));

  long_op_scoreboard #(
    .REG_AW   (REG_AW),
    .LONG_LAT (LONG_LAT)
  ) u_sb (
    .clk          (clk),
    .rst          (rst),
    .issue_i      (long_issue),
    .issue_addr_i (id_wr_addr),
    .id_uses_rs_i (id_uses_rs),
    .id_uses_rt_i (id_uses_rt),
    .id_is_long_i (id_is_long),
    .id_rs_i      (id_rs),
    .id_rt_i      (id_rt),
    .id_wr_addr_i (id_wr_addr),
    .busy_o       (sb_busy),
    .match_o      (sb_match)
  );

  assign long_stall = sb_busy && id_valid && sb_match;
  assign stall      = load_use || long_stall;
  // A redirect kills the ID instruction, so a long op there must not start.
  assign long_issue = id_valid && id_is_long && !stall && !br_taken;

  // Pipeline register controls: a taken branch overrides any stall.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    flush_ifid  = 1'b0;
    if (br_taken) begin
      flush_ifid  = 1'b1;
      idex_bubble = 1'b1;
    end else if (stall) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

`ifdef HAZARD_PERF_EN
  localparam logic [PERF_W-1:0] PERF_MAX = '1;

  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [PERF_W-1:0] flush_cnt_q, flush_cnt_d;

  // Saturating counters: a pegged counter reads as "at least this many".
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && !br_taken && (stall_cnt_q != PERF_MAX))
      stall_cnt_d = stall_cnt_q + PERF_W'(1);
    if (br_taken && (flush_cnt_q != PERF_MAX))
      flush_cnt_d = flush_cnt_q + PERF_W'(1);
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule
